// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment controller.
// Also holds the per-iteration double-dabble nibble correction.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int          DIGITS    = 4;
  localparam int          ITERS     = 16;
  localparam logic [7:0]  BLANK_SEG = 8'hFF;
  localparam logic [3:0]  OVF_CODE  = 4'hE;
  localparam logic [15:0] DEC_MAX   = 16'd9999;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder7.sv
// Nibble to active-low seven-segment pattern, bit order g..a (bit 0 = segment a).
// Covers the full hex range; 4'hE doubles as the overflow glyph.
module decoder7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display driver: hex load is immediate, decimal load runs a
// 16-cycle sequential double-dabble while the old digits stay on screen.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic        HexMode,
  output logic        Busy,
  output logic [7:0]  Seg,
  output logic [3:0]  An,
  output state_t      DbgState
);

  localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);

  state_t         state_q, state_d;
  logic [15:0]    digits_q;
  logic           hex_q;
  logic [15:0]    bin_q;
  logic [15:0]    bcd_q;
  logic           ovf_q;
  logic [3:0]     iter_q;
  logic [PW-1:0]  presc_q;
  logic [1:0]     scan_q;

  logic           load_hex, load_dec, commit;
  logic [15:0]    bcd_adj, bcd_next;
  logic [3:0]     blank;
  logic [3:0]     nib;
  logic [6:0]     seg7;

  // Handshake: Load is a one-cycle request taken only when Busy is low; a
  // request seen while Busy is high is dropped, never queued.

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_hex = 1'b0;
    load_dec = 1'b0;
    commit   = 1'b0;
    Busy     = (state_q == CONV);
    case (state_q)
      IDLE: begin
        if (Load) begin
          if (HexMode) begin
            load_hex = 1'b1;
          end else begin
            load_dec = 1'b1;
            state_d  = CONV;
          end
        end
      end
      CONV: begin
        if (iter_q == 4'(ITERS - 1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DbgState = state_q;

  assign bcd_adj  = dabble_adjust(bcd_q);
  assign bcd_next = {bcd_adj[14:0], bin_q[15]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      digits_q <= '0;
      hex_q    <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      iter_q   <= '0;
    end else begin
      if (load_hex) begin
        digits_q <= Value;
        hex_q    <= 1'b1;
      end
      if (load_dec) begin
        bin_q  <= Value;
        bcd_q  <= '0;
        ovf_q  <= (Value > DEC_MAX);
        iter_q <= '0;
      end
      if (state_q == CONV) begin
        {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
        iter_q         <= iter_q + 4'd1;
      end
      // Mode flips to decimal only on commit so blanking of the old digits holds.
      if (commit) begin
        digits_q <= ovf_q ? {DIGITS{OVF_CODE}} : bcd_next;
        hex_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      scan_q  <= scan_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Leading-zero blanking cascades down from digit 3; digit 0 always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = !hex_q && (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
  end

  always_comb begin
    nib = digits_q[3:0];
    case (scan_q)
      2'd0: nib = digits_q[3:0];
      2'd1: nib = digits_q[7:4];
      2'd2: nib = digits_q[11:8];
      2'd3: nib = digits_q[15:12];
      default: nib = digits_q[3:0];
    endcase
  end

  decoder7 u_dec (
    .nibble (nib),
    .seg    (seg7)
  );

  always_comb begin
    An  = ~(4'b0001 << scan_q);
    Seg = {1'b1, seg7};
    if (blank[scan_q]) begin
      An  = 4'b1111;
      Seg = BLANK_SEG;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-cycle expected frames go into a queue,
// a negedge monitor pops and compares them against two instances (divide 1 and 3).
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  // clock / reset
  logic        clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Value;
  logic        HexMode;
  logic        busy1, busy3;
  logic [7:0]  seg1, seg3;
  logic [3:0]  an1, an3;
  state_t      dbg1, dbg3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(1)) dut (
    .Clk(clk), .Reset(Reset), .Load(Load), .Value(Value), .HexMode(HexMode),
    .Busy(busy1), .Seg(seg1), .An(an1), .DbgState(dbg1)
  );

  seg_scan_ctrl #(.REFRESH_DIV(3)) dut3 (
    .Clk(clk), .Reset(Reset), .Load(Load), .Value(Value), .HexMode(HexMode),
    .Busy(busy3), .Seg(seg3), .An(an3), .DbgState(dbg3)
  );

  // scoreboard: frame = {busy[16], an[15:12], seg[11:4], an_div3[3:0]}
  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // expected display content (hand-computed patterns) and scan models
  logic [7:0] d_seg[4];
  logic [3:0] d_blank;
  logic       e_busy;
  int         scan = 0;
  int         scan3 = 0;
  int         presc3 = 0;

  function automatic logic [16:0] frame();
    logic [3:0] a, a3;
    logic [7:0] s;
    a  = d_blank[scan]  ? 4'b1111 : ~(4'b0001 << scan);
    s  = d_blank[scan]  ? 8'hFF   : d_seg[scan];
    a3 = d_blank[scan3] ? 4'b1111 : ~(4'b0001 << scan3);
    return {e_busy, a, s, a3};
  endfunction

  // One clock edge; the pushed frame describes outputs after that edge.
  task automatic tick();
    logic r;
    r = Reset;
    @(posedge clk);
    if (r) begin
      scan = 0; scan3 = 0; presc3 = 0;
    end else begin
      scan = (scan + 1) % 4;
      if (presc3 == 2) begin
        presc3 = 0;
        scan3  = (scan3 + 1) % 4;
      end else begin
        presc3++;
      end
    end
    #1;
    exp_q.push_back(frame());
  endtask

  task automatic set_disp(input logic [7:0] s0, s1, s2, s3, input logic [3:0] bl);
    d_seg[0] = s0; d_seg[1] = s1; d_seg[2] = s2; d_seg[3] = s3;
    d_blank  = bl;
  endtask

  task automatic do_hex(input logic [15:0] v, input logic [7:0] s0, s1, s2, s3);
    Load = 1'b1; Value = v; HexMode = 1'b1;
    set_disp(s0, s1, s2, s3, 4'b0000);
    e_busy = 1'b0;
    tick();
    Load = 1'b0;
    repeat (4) tick();
  endtask

  // Decimal load; optional ignored reload at busy cycle ign_at, reset at rst_at.
  task automatic do_dec(input logic [15:0] v, input logic [7:0] s0, s1, s2, s3,
                        input logic [3:0] bl, input int ign_at, input int rst_at);
    Load = 1'b1; Value = v; HexMode = 1'b0;
    e_busy = 1'b1;
    tick();
    Load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == ign_at) begin
        Load = 1'b1; Value = 16'd5678; HexMode = 1'b0;
      end
      if (c == rst_at) begin
        Reset  = 1'b1;
        e_busy = 1'b0;
        set_disp(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b1110);
        tick();
        Reset = 1'b0;
        break;
      end
      if (c == 16) begin
        e_busy = 1'b0;
        set_disp(s0, s1, s2, s3, bl);
      end
      tick();
      Load = 1'b0;
    end
    repeat (4) tick();
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    logic [16:0] f;
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      checks++;
      if (busy1 !== f[16]) begin
        errors++;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, busy1, f[16]);
      end
      checks++;
      if (an1 !== f[15:12]) begin
        errors++;
        $display("FAIL an t=%0t got=%b exp=%b", $time, an1, f[15:12]);
      end
      checks++;
      if (seg1 !== f[11:4]) begin
        errors++;
        $display("FAIL seg t=%0t got=%h exp=%h", $time, seg1, f[11:4]);
      end
      checks++;
      if (an3 !== f[3:0]) begin
        errors++;
        $display("FAIL an_div3 t=%0t got=%b exp=%b", $time, an3, f[3:0]);
      end
    end
  end

  // stimulus
  initial begin
    Reset = 1'b1; Load = 1'b0; Value = 16'd0; HexMode = 1'b0;
    e_busy = 1'b0;
    set_disp(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b1110);
    tick();
    tick();
    Reset = 1'b0;
    repeat (6) tick();

    do_hex(16'hA3F0, 8'hC0, 8'h8E, 8'hB0, 8'h88);
    do_dec(16'd1234, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000, 0, 0);
    do_dec(16'd7,    8'hF8, 8'hFF, 8'hFF, 8'hFF, 4'b1110, 0, 0);
    do_dec(16'd10000, 8'h86, 8'h86, 8'h86, 8'h86, 4'b0000, 0, 0);
    do_dec(16'd9999, 8'h90, 8'h90, 8'h90, 8'h90, 4'b0000, 0, 0);
    do_dec(16'd405,  8'h92, 8'hC0, 8'h99, 8'hFF, 4'b1000, 0, 0);
    do_dec(16'd0,    8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b1110, 0, 0);
    do_dec(16'd1234, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000, 3, 0);
    do_dec(16'd1234, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000, 0, 8);
    do_hex(16'h1F2E, 8'h86, 8'hA4, 8'h8E, 8'hF9);

    // reset wins over a simultaneous hex load
    Reset = 1'b1; Load = 1'b1; Value = 16'hBEEF; HexMode = 1'b1;
    e_busy = 1'b0;
    set_disp(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b1110);
    tick();
    Reset = 1'b0; Load = 1'b0;
    repeat (5) tick();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 frames left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
